// File: rtl/mux6_rr_arbiter_if.sv
// Bus bundle for mux6_rr_arbiter: requests, per-requester data lines,
// and the registered grant/select/data outputs.
// MUX6_ARB_LOCK_EN adds the owner lock input.
interface mux6_rr_arbiter_if;
  logic [5:0] req;
  logic [5:0] din;
  logic [5:0] grant;
  logic [2:0] sel;
  logic       dout;
  logic       dout_vld;
`ifdef MUX6_ARB_LOCK_EN
  logic       lock;

  modport master (output req, din, lock, input grant, sel, dout, dout_vld);
  modport slave  (input req, din, lock, output grant, sel, dout, dout_vld);
`else
  modport master (output req, din, input grant, sel, dout, dout_vld);
  modport slave  (input req, din, output grant, sel, dout, dout_vld);
`endif
endinterface

// File: rtl/mux6_rr_arbiter.sv
// mux6_rr_arbiter: six-way round-robin arbiter with a per-owner burst
// limit, driving a registered 6:1 data mux from the owner index.
// Optional feature: define MUX6_ARB_LOCK_EN to add a lock input that lets
// the owner keep the grant past its burst limit.

// Plain 6:1 data mux; out-of-range selects yield 0.
module mux6 (
  input  logic [5:0] d,
  input  logic [2:0] s,
  output logic       y
);
  // combinational select
  always_comb begin
    y = 1'b0;
    case (s)
      3'd0: y = d[0];
      3'd1: y = d[1];
      3'd2: y = d[2];
      3'd3: y = d[3];
      3'd4: y = d[4];
      3'd5: y = d[5];
      default: y = 1'b0;
    endcase
  end
endmodule

module mux6_rr_arbiter #(
  parameter int unsigned BURST = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  mux6_rr_arbiter_if.slave bus
);
  typedef enum logic { IDLE = 1'b0, BUSY = 1'b1 } state_t;

  localparam logic [3:0] CNT_LAST = 4'(BURST - 1);

  state_t     state;
  logic [2:0] ptr;
  logic [3:0] cnt;
  logic [5:0] grant_q;
  logic [2:0] sel_q;
  logic       dout_q;
  logic       dout_vld_q;

  logic [5:0] others;
  logic       own_req;
  logic       last;
  logic       hold;
  logic       rel;
  logic [5:0] search_req;
  logic [2:0] search_start;
  logic [2:0] own_nxt;
  logic       found;
  logic [2:0] cand;
  logic       mux_y;

  // First set bit of r scanning start, start+1, ... wrapping 5->0.
  // Result is {found, index}.
  function automatic logic [3:0] pick(input logic [5:0] r, input logic [2:0] start);
    logic [11:0] dbl;
    logic [5:0]  rot;
    logic [3:0]  idx;
    logic [3:0]  res;
    dbl = {r, r} >> start;
    rot = dbl[5:0];
    res = 4'd0;
    idx = 4'd0;
    // descending scan so the lowest rotated position wins
    for (int k = 5; k >= 0; k--) begin
      if (rot[k]) begin
        idx = {1'b0, start} + 4'(k);
        if (idx >= 4'd6) idx = idx - 4'd6;
        res = {1'b1, idx[2:0]};
      end
    end
    return res;
  endfunction

  // Release decision and next-owner search for the current cycle.
  always_comb begin
    others  = bus.req & ~grant_q;
    own_req = |(bus.req & grant_q);
    last    = (cnt == CNT_LAST);
`ifdef MUX6_ARB_LOCK_EN
    hold    = bus.lock & own_req;
`else
    hold    = 1'b0;
`endif
    rel     = !own_req || (last && (|others) && !hold);
    own_nxt = (sel_q == 3'd5) ? 3'd0 : sel_q + 3'd1;
    // in BUSY the released owner is excluded and the search starts after it
    search_req   = (state == IDLE) ? bus.req : others;
    search_start = (state == IDLE) ? ptr : own_nxt;
    {found, cand} = pick(search_req, search_start);
  end

  mux6 u_mux (.d(bus.din), .s(sel_q), .y(mux_y));

  // Arbiter FSM with registered grant/select and burst counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      grant_q <= 6'd0;
      sel_q   <= 3'd0;
      ptr     <= 3'd0;
      cnt     <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            state   <= BUSY;
            grant_q <= 6'(1) << cand;
            sel_q   <= cand;
            cnt     <= 4'd0;
          end
        end
        BUSY: begin
          if (rel) begin
            ptr <= own_nxt;
            cnt <= 4'd0;
            if (found) begin
              grant_q <= 6'(1) << cand;
              sel_q   <= cand;
            end else begin
              state   <= IDLE;
              grant_q <= 6'd0;
              sel_q   <= 3'd0;
            end
          end else if (last) begin
            // locked owner with waiters parks at the limit; otherwise a
            // lone owner starts a fresh burst
            cnt <= (hold && (|others)) ? cnt : 4'd0;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        default: begin
          state   <= IDLE;
          grant_q <= 6'd0;
          sel_q   <= 3'd0;
        end
      endcase
    end
  end

  // Registered data output, valid only on cycles with an owner.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dout_q     <= 1'b0;
      dout_vld_q <= 1'b0;
    end else begin
      dout_q     <= (state == BUSY) ? mux_y : 1'b0;
      dout_vld_q <= (state == BUSY);
    end
  end

  assign bus.grant    = grant_q;
  assign bus.sel      = sel_q;
  assign bus.dout     = dout_q;
  assign bus.dout_vld = dout_vld_q;
endmodule

// File: tb/tb_mux6_rr_arbiter.sv
// Scoreboard bench for mux6_rr_arbiter: directed scenarios followed by
// random traffic, compared against a cycle-level ownership model.
module tb_mux6_rr_arbiter;
  localparam int BURST = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  mux6_rr_arbiter_if bus ();

  mux6_rr_arbiter #(.BURST(BURST)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0] grant;
    logic [2:0] sel;
    logic       dout;
    logic       vld;
  } exp_t;

  exp_t q[$];

  // reference model state
  int         m_owner = -1;
  int         m_ptr = 0;
  int         m_held = 0;
  int         m_w;
  logic [5:0] m_rest;
  bit         m_wants, m_waiting, m_locked;
  exp_t       m_e;

  function automatic int first_req(input logic [5:0] r, input int start);
    for (int k = 0; k < 6; k++)
      if (r[(start + k) % 6]) return (start + k) % 6;
    return -1;
  endfunction

  function automatic bit lock_now();
`ifdef MUX6_ARB_LOCK_EN
    return bus.lock;
`else
    return 1'b0;
`endif
  endfunction

  // Model: predict the outputs visible after this edge.
  always @(posedge clk) begin
    if (!rst_n) begin
      m_owner = -1; m_ptr = 0; m_held = 0;
      m_e.dout = 1'b0; m_e.vld = 1'b0;
    end else begin
      m_e.vld  = (m_owner >= 0);
      m_e.dout = (m_owner >= 0) ? bus.din[m_owner] : 1'b0;
      if (m_owner < 0) begin
        m_w = first_req(bus.req, m_ptr);
        if (m_w >= 0) begin m_owner = m_w; m_held = 0; end
      end else begin
        m_rest = bus.req;
        m_rest[m_owner] = 1'b0;
        m_wants   = bus.req[m_owner];
        m_waiting = (m_rest != 6'd0);
        m_locked  = lock_now() && m_wants;
        if (!m_wants || (m_held == BURST - 1 && m_waiting && !m_locked)) begin
          m_ptr = (m_owner + 1) % 6;
          m_owner = first_req(m_rest, m_ptr);
          m_held = 0;
        end else if (m_held == BURST - 1) begin
          m_held = (m_locked && m_waiting) ? m_held : 0;
        end else begin
          m_held++;
        end
      end
    end
    m_e.grant = (m_owner < 0) ? 6'd0 : 6'(1) << m_owner;
    m_e.sel   = (m_owner < 0) ? 3'd0 : 3'(m_owner);
    q.push_back(m_e);
  end

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
    end
  endtask

  // Monitor: pop one prediction per cycle and compare after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("grant", int'(bus.grant), int'(e.grant));
        chk("sel", int'(bus.sel), int'(e.sel));
        chk("dout_vld", int'(bus.dout_vld), int'(e.vld));
        chk("dout", int'(bus.dout), int'(e.dout));
      end
    end
  end

  task automatic step(input logic [5:0] r, input logic l, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.req = r;
      bus.din = 6'($urandom);
`ifdef MUX6_ARB_LOCK_EN
      bus.lock = l;
`endif
    end
  endtask

  initial begin
    logic [5:0] r;
    logic       l;
    bus.req = 6'd0;
    bus.din = 6'd0;
`ifdef MUX6_ARB_LOCK_EN
    bus.lock = 1'b0;
`endif
    // requests during reset are ignored
    step(6'b111111, 1'b0, 2);
    rst_n = 1'b1;
    // single requester 0
    step(6'b000001, 1'b0, 3);
    step(6'b000000, 1'b0, 2);
    // 0 and 5 alternate bursts with wrap
    step(6'b100001, 1'b0, 14);
    step(6'b000000, 1'b0, 1);
    // owner 2 drops, 3 takes over without idle
    step(6'b001100, 1'b0, 2);
    step(6'b001000, 1'b0, 3);
    step(6'b000000, 1'b0, 1);
    // lone requester 4 keeps the grant across burst limits
    step(6'b010000, 1'b0, 10);
    step(6'b000000, 1'b0, 2);
    // reset while owner 3 is busy, all request afterwards
    step(6'b001000, 1'b0, 2);
    rst_n = 1'b0;
    step(6'b111111, 1'b0, 1);
    rst_n = 1'b1;
    step(6'b111111, 1'b0, 6);
    step(6'b000000, 1'b0, 1);
`ifdef MUX6_ARB_LOCK_EN
    // locked owner 1 holds against waiting requester 2
    step(6'b000010, 1'b0, 1);
    step(6'b000110, 1'b1, 8);
    step(6'b000110, 1'b0, 2);
    step(6'b000000, 1'b0, 1);
`endif
    // random traffic with sticky requests and occasional reset
    r = 6'd0;
    l = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(3) == 0) r = 6'($urandom);
      if ($urandom_range(2) == 0) l = 1'($urandom);
      rst_n = ($urandom_range(199) != 0);
      step(r, l, 1);
    end
    rst_n = 1'b1;
    step(6'd0, 1'b0, 3);
    @(posedge clk);
    #2;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mux6_rr_arbiter.md
MUX6_RR_ARBITER -- requirements
Module: mux6_rr_arbiter

Interface
REQ-001 SHALL have parameter: BURST, 4, max consecutive grant cycles per owner while others wait (legal 1..15).
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on posedge.
REQ-003 SHALL have port: rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port: req  input  6  request, bit i = requester i.
REQ-005 SHALL have port: din  input  6  data lines; bit i driven by requester i.
REQ-006 SHALL have port: grant  output  6  one-hot (or zero) registered grant.
REQ-007 SHALL have port: sel  output  3  binary index of current owner; drives the 6:1 data mux.
REQ-008 SHALL have port: dout  output  1  registered din[sel], gated by ownership.
REQ-009 SHALL have port: dout_vld  output  1  dout carries owner data.
REQ-010 SHALL have port, only with MUX6_ARB_LOCK_EN defined: lock  input  1  owner extends grant past BURST.

Function
REQ-011 SHALL implement FSM with states IDLE (no owner) and BUSY (one owner); grant, sel, and current state are registered.
REQ-012 SHALL keep round-robin pointer ptr (0..5): search order ptr, ptr+1, ... mod 6, wrapping 5->0.
REQ-013 IDLE: any req bit set at posedge -> next cycle BUSY, owner = first set bit in search order; grant latency exactly 1 cycle.
REQ-014 BUSY: burst counter cnt (4 bits) = 0 on grant start, +1 each cycle the owner is retained.
REQ-015 BUSY release when req[owner]=0, or when cnt==BURST-1 and any other req bit set.
REQ-016 On release, ptr <= owner+1 mod 6; next owner chosen in same cycle from new search order excluding the released owner; direct owner-to-owner switch, no IDLE bubble.
REQ-017 On release with no eligible requester -> IDLE, grant=0.
REQ-018 cnt==BURST-1 with no other requester -> retain owner, cnt restarts at 0.
REQ-019 Owner deasserting req in the same cycle its burst expires is a single release; ptr update once.
REQ-020 grant SHALL be one-hot in BUSY, 0 in IDLE; sel SHALL equal owner index in BUSY, 3'd0 in IDLE; sel SHALL never be 6 or 7.
REQ-021 dout <= din[sel] and dout_vld <= 1 on each BUSY cycle; dout, dout_vld <= 0 on IDLE cycles; one-cycle latency relative to grant/sel.
REQ-022 Data path SHALL be selected by a 6:1 mux instance driven by sel; no direct din indexing outside it.
REQ-023 Changes to req bits other than the owner's SHALL not affect grant except at burst expiry.

Reset
REQ-024 rst_n=0 at posedge: state=IDLE, grant=0, sel=0, ptr=0, cnt=0, dout=0, dout_vld=0.
REQ-025 Reset mid-BUSY SHALL drop grant on the next posedge; first post-reset grant follows REQ-013 with ptr=0.
REQ-026 req sampled during reset SHALL be ignored.

Configuration
REQ-027 Macro MUX6_ARB_LOCK_EN defined: lock port exists; lock=1 with req[owner]=1 suppresses burst-expiry release, cnt holds at BURST-1; release resumes the first cycle lock=0 with others waiting.
REQ-028 Macro undefined: no lock port; release purely per REQ-015.

Verification
REQ-029 Reset, then req=6'b000001 -> after 1 cycle grant=6'b000001, sel=0; next cycle dout=din[0], dout_vld=1.
REQ-030 BURST=4, req=6'b100001 held from IDLE -> req0 owns 4 cycles, then grant=6'b100000, sel=5 for 4 cycles, then back to req0 (wrap).
REQ-031 req=6'b001100, owner 2 drops req after 2 cycles -> next cycle grant=6'b001000, sel=3, no IDLE cycle.
REQ-032 Single requester 4 held 10 cycles, BURST=4 -> grant stays 6'b010000 all 10 cycles; drop req -> IDLE, dout_vld=0 one cycle later.
REQ-033 rst_n=0 for one cycle while owner 3 BUSY -> grant=0, sel=0, dout_vld=0 after posedge; with req=6'b111111 after reset -> owner 0 first.
REQ-034 MUX6_ARB_LOCK_EN defined, owner 1 with lock=1, req=6'b000110, 8 cycles -> owner 1 retained; lock=0 -> next cycle grant=6'b000100.
